// File: rtl/game_pkg.sv
// Shared game-level constants: game FSM codes, frame phase indices,
// phase masks and small helpers used by the frame sequencer.
package game_pkg;

  // Game FSM codes driven by the top-level game controller
  localparam logic [2:0] GS_START    = 3'b000;
  localparam logic [2:0] GS_PLAYING  = 3'b001;
  localparam logic [2:0] GS_PAUSE    = 3'b010;
  localparam logic [2:0] GS_RESET    = 3'b011;
  localparam logic [2:0] GS_GAMEOVER = 3'b100;

  // Engine phases, in the order they run within a frame
  localparam int NUM_PHASES = 4;
  localparam logic [1:0] PH_INPUT   = 2'd0;
  localparam logic [1:0] PH_MOVE    = 2'd1;
  localparam logic [1:0] PH_COLLIDE = 2'd2;
  localparam logic [1:0] PH_RENDER  = 2'd3;

  // Phase masks: full pipeline while playing, input+render otherwise
  localparam logic [3:0] MASK_FULL    = 4'b1111;
  localparam logic [3:0] MASK_MINIMAL = 4'b1001;
  localparam logic [3:0] MASK_NONE    = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } seq_state_e;

  // Result of a search for the next phase to run
  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } phase_sel_t;

  // Phases enabled for a frame started under the given game state
  function automatic logic [3:0] phase_mask(input logic [2:0] gs);
    case (gs)
      GS_PLAYING:                      return MASK_FULL;
      GS_START, GS_PAUSE, GS_GAMEOVER: return MASK_MINIMAL;
      default:                         return MASK_NONE;
    endcase
  endfunction

  // Lowest set mask bit at or above 'from' (from may be 4 = past the end)
  function automatic phase_sel_t next_phase(input logic [3:0] mask,
                                            input logic [2:0] from);
    phase_sel_t s;
    s = '0;
    for (int i = NUM_PHASES - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        s.found = 1'b1;
        s.idx   = 2'(i);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase watchdog: counts cycles while enabled, flags expiry on the
// cycle the count reaches TIMEOUT-1. Clear restarts it for a new phase.
module phase_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count_q;

  assign expired = enable && (count_q == 16'(TIMEOUT - 1));

  // Cycle counter; holds once expired so it never wraps back to zero
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + 16'd1;
    end
  end

endmodule

// File: rtl/frame_phase_sequencer.sv
// Frame phase sequencer: on each accepted vertical-blank pulse, walks the
// engines selected by the game state (input, move, collide, render) one at a
// time, waiting for each engine's done pulse under a per-phase watchdog.
module frame_phase_sequencer
  import game_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  game_state,
  input  logic        frame_start,
  input  logic [3:0]  phase_done,
  output logic [3:0]  phase_start,
  output logic        busy,
  output logic        clear_engines,
  output logic [15:0] frame_count,
  output logic        frame_overrun,
  output logic        timeout_err
);

  seq_state_e  state_q;
  logic [1:0]  idx_q;
  logic [3:0]  mask_q;
  logic [15:0] frame_count_q;
  logic        overrun_q;
  logic        timeout_q;
  logic [2:0]  prev_gs_q;

  logic        wd_expired;
  logic [3:0]  new_mask;
  phase_sel_t  start_sel;
  phase_sel_t  next_sel;
  logic        in_reset_state;

  assign in_reset_state = (game_state == GS_RESET);
  assign new_mask       = phase_mask(game_state);
  assign start_sel      = next_phase(new_mask, 3'd0);
  assign next_sel       = next_phase(mask_q, {1'b0, idx_q} + 3'd1);

  phase_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == ST_ISSUE),
    .enable  (state_q == ST_WAIT),
    .expired (wd_expired)
  );

  // Sequencer FSM plus frame counter and sticky status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      mask_q        <= MASK_NONE;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
      prev_gs_q     <= GS_RESET;
    end else begin
      prev_gs_q <= game_state;
      if (in_reset_state) begin
        // Game reset aborts any frame and wipes status
        state_q       <= ST_IDLE;
        frame_count_q <= '0;
        overrun_q     <= 1'b0;
        timeout_q     <= 1'b0;
      end else begin
        // A frame_start that arrives while busy is dropped, never queued
        if (frame_start && (state_q != ST_IDLE)) overrun_q <= 1'b1;
        case (state_q)
          ST_IDLE: begin
            if (frame_start && start_sel.found) begin
              mask_q  <= new_mask;
              idx_q   <= start_sel.idx;
              state_q <= ST_ISSUE;
            end
          end
          ST_ISSUE: state_q <= ST_WAIT;
          ST_WAIT: begin
            // Done takes priority over a coincident watchdog expiry
            if (phase_done[idx_q]) begin
              if (next_sel.found) begin
                idx_q   <= next_sel.idx;
                state_q <= ST_ISSUE;
              end else begin
                state_q       <= ST_IDLE;
                frame_count_q <= frame_count_q + 16'd1;
              end
            end else if (wd_expired) begin
              timeout_q <= 1'b1;
              state_q   <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign phase_start   = (state_q == ST_ISSUE && !in_reset_state && !reset)
                         ? (4'b0001 << idx_q) : 4'b0000;
  assign busy          = (state_q != ST_IDLE);
  assign clear_engines = !reset && in_reset_state && (prev_gs_q != GS_RESET);
  assign frame_count   = frame_count_q;
  assign frame_overrun = overrun_q;
  assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_frame_phase_sequencer.sv
// Bench for frame_phase_sequencer: directed frames followed by randomized
// traffic, every cycle compared against a queue-based frame model.
module tb_frame_phase_sequencer;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  game_state;
  logic        frame_start;
  logic [3:0]  phase_done;
  logic [3:0]  phase_start;
  logic        busy;
  logic        clear_engines;
  logic [15:0] frame_count;
  logic        frame_overrun;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;

  frame_phase_sequencer #(.TIMEOUT(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .game_state    (game_state),
    .frame_start   (frame_start),
    .phase_done    (phase_done),
    .phase_start   (phase_start),
    .busy          (busy),
    .clear_engines (clear_engines),
    .frame_count   (frame_count),
    .frame_overrun (frame_overrun),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is a queue of pending phases
  bit          m_busy, m_issuing, m_ovr, m_to;
  int          m_cur, m_waited;
  int          m_todo[$];
  logic [15:0] m_count;
  logic [2:0]  m_prev;
  logic [3:0]  last_ps;
  logic        last_ce;

  function automatic logic [3:0] mask_of(input logic [2:0] gs);
    if (gs == 3'd1) return 4'hF;
    if (gs == 3'd0 || gs == 3'd2 || gs == 3'd4) return 4'h9;
    return 4'h0;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input logic [2:0] gs, input bit fs, input logic [3:0] pd);
    logic [3:0] mk;
    if (r) begin
      m_busy = 0; m_issuing = 0; m_todo.delete(); m_cur = 0; m_waited = 0;
      m_count = '0; m_ovr = 0; m_to = 0; m_prev = 3'd3;
      return;
    end
    m_prev = gs;
    if (gs == 3'd3) begin
      m_busy = 0; m_issuing = 0; m_todo.delete();
      m_count = '0; m_ovr = 0; m_to = 0;
      return;
    end
    if (!m_busy) begin
      mk = mask_of(gs);
      if (fs && mk != 4'h0) begin
        for (int i = 0; i < 4; i++) if (mk[i]) m_todo.push_back(i);
        m_cur = m_todo.pop_front();
        m_busy = 1; m_issuing = 1;
      end
    end else begin
      if (fs) m_ovr = 1;
      if (m_issuing) begin
        m_issuing = 0; m_waited = 0;
      end else if (pd[m_cur]) begin
        if (m_todo.size() > 0) begin
          m_cur = m_todo.pop_front(); m_issuing = 1;
        end else begin
          m_busy = 0; m_count++;
        end
      end else if (m_waited == TMO - 1) begin
        m_to = 1; m_busy = 0; m_todo.delete();
      end else begin
        m_waited++;
      end
    end
  endtask

  // One clock cycle: drive, check against the model, advance model and clock
  task automatic cyc(input bit r, input logic [2:0] gs, input bit fs, input logic [3:0] pd);
    logic [3:0] eps;
    reset = r; game_state = gs; frame_start = fs; phase_done = pd;
    #1;
    eps = 4'b0001 << m_cur;
    if (r || !m_issuing || gs == 3'd3) eps = 4'h0;
    chk("phase_start",   {12'h0, phase_start},   {12'h0, eps});
    chk("busy",          {15'h0, busy},          {15'h0, m_busy});
    chk("frame_count",   frame_count,            m_count);
    chk("frame_overrun", {15'h0, frame_overrun}, {15'h0, m_ovr});
    chk("timeout_err",   {15'h0, timeout_err},   {15'h0, m_to});
    chk("clear_engines", {15'h0, clear_engines},
        {15'h0, (!r && gs == 3'd3 && m_prev != 3'd3)});
    last_ps = phase_start;
    last_ce = clear_engines;
    model_step(r, gs, fs, pd);
    @(posedge clk);
    #1;
  endtask

  // Run one frame; each started phase is answered 3 cycles later unless hung
  task automatic run_frame(input logic [2:0] gs, input int hang_ph, input int ovr_ph,
                           input int noise_ph, output int n, output logic [15:0] order,
                           output int tail);
    int cd, pend, ncd, start_it;
    bit fs_nxt;
    logic [3:0] pd;
    n = 0; order = '0; tail = -1; cd = 0; pend = 0; ncd = 0; start_it = 0; fs_nxt = 0;
    cyc(1'b0, gs, 1'b1, 4'h0);
    for (int it = 1; it <= 80; it++) begin
      pd = 4'h0;
      if (cd > 0) begin
        if (cd == 1) pd[pend] = 1'b1;
        cd--;
      end
      if (ncd > 0) begin
        if (ncd == 1 && noise_ph >= 0) pd[noise_ph] = 1'b1;
        ncd--;
      end
      cyc(1'b0, gs, fs_nxt, pd);
      fs_nxt = 0;
      if (last_ps != 4'h0) begin
        for (int b = 0; b < 4; b++) if (last_ps[b]) pend = b;
        if (n < 4) order[4*n +: 4] = 4'(pend);
        n++;
        start_it = it;
        if (pend != hang_ph) cd = 3;
        if (pend == 0) ncd = 2;
        if (pend == ovr_ph) fs_nxt = 1;
      end
      if (n > 0 && !busy) begin
        tail = it - start_it;
        break;
      end
    end
    chk("frame_end_busy", {15'h0, busy}, 16'h0);
  endtask

  initial begin
    int n, tail;
    logic [15:0] order;
    logic [3:0] ps_or;
    logic [2:0] gs;
    bit r, fs;
    logic [3:0] pd;
    int sel;

    reset = 1'b1; game_state = 3'd3; frame_start = 1'b0; phase_done = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    model_step(1'b1, 3'd3, 1'b0, 4'h0);

    // Reset state, then leave game in RESET: no clear pulse may follow reset
    cyc(1'b1, 3'd3, 1'b0, 4'h0);
    chk("rst_count", frame_count, 16'h0);
    chk("rst_flags", {14'h0, frame_overrun, timeout_err}, 16'h0);
    cyc(1'b0, 3'd3, 1'b0, 4'h0);
    chk("rst_no_clear", {15'h0, last_ce}, 16'h0);
    cyc(1'b0, 3'd3, 1'b1, 4'h0);
    cyc(1'b0, 3'd1, 1'b0, 4'h0);

    // PLAYING frame: all four phases in order
    run_frame(3'd1, -1, -1, -1, n, order, tail);
    chk("play_nstarts", 16'(n), 16'd4);
    chk("play_order", order, 16'h3210);
    chk("play_count", frame_count, 16'd1);
    chk("play_tail", 16'(tail), 16'd3);
    cyc(1'b0, 3'd2, 1'b0, 4'h0);

    // PAUSE frame: input then render; stray done for phase 1 ignored
    run_frame(3'd2, -1, -1, 1, n, order, tail);
    chk("pause_nstarts", 16'(n), 16'd2);
    chk("pause_order", order, 16'h0030);
    chk("pause_count", frame_count, 16'd2);
    cyc(1'b0, 3'd1, 1'b0, 4'h0);

    // Phase 1 hangs: watchdog aborts after 8 WAIT cycles
    run_frame(3'd1, 1, -1, -1, n, order, tail);
    chk("tmo_nstarts", 16'(n), 16'd2);
    chk("tmo_tail", 16'(tail), 16'd8);
    chk("tmo_err", {15'h0, timeout_err}, 16'h1);
    chk("tmo_count", frame_count, 16'd2);
    cyc(1'b0, 3'd1, 1'b0, 4'h0);

    // frame_start during phase 2: flagged and dropped, frame still completes
    run_frame(3'd1, -1, 2, -1, n, order, tail);
    chk("ovr_order", order, 16'h3210);
    chk("ovr_flag", {15'h0, frame_overrun}, 16'h1);
    chk("ovr_count", frame_count, 16'd3);
    cyc(1'b0, 3'd1, 1'b0, 4'h0);
    cyc(1'b0, 3'd1, 1'b0, 4'h0);
    chk("ovr_no_queue", {15'h0, busy}, 16'h0);

    // Game reset in the middle of phase 1
    cyc(1'b0, 3'd1, 1'b1, 4'h0);
    cyc(1'b0, 3'd1, 1'b0, 4'h0);
    cyc(1'b0, 3'd1, 1'b0, 4'h1);
    cyc(1'b0, 3'd1, 1'b0, 4'h0);
    chk("greset_ph1", {12'h0, last_ps}, 16'h2);
    cyc(1'b0, 3'd1, 1'b0, 4'h0);
    cyc(1'b0, 3'd3, 1'b0, 4'h0);
    chk("greset_clear", {15'h0, last_ce}, 16'h1);
    chk("greset_idle", {15'h0, busy}, 16'h0);
    chk("greset_count", frame_count, 16'h0);
    chk("greset_flags", {14'h0, frame_overrun, timeout_err}, 16'h0);
    cyc(1'b0, 3'd3, 1'b0, 4'h2);
    chk("greset_clear_once", {15'h0, last_ce}, 16'h0);
    ps_or = 4'h0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 3'd1, 1'b0, 4'hF);
      ps_or |= last_ps;
    end
    chk("greset_no_start", {12'h0, ps_or}, 16'h0);

    // Counter wrap from 0xFFFF
    force dut.frame_count_q = 16'hFFFF;
    m_count = 16'hFFFF;
    cyc(1'b0, 3'd2, 1'b0, 4'h0);
    release dut.frame_count_q;
    chk("wrap_preset", frame_count, 16'hFFFF);
    run_frame(3'd2, -1, -1, -1, n, order, tail);
    chk("wrap_count", frame_count, 16'h0000);

    // Randomized traffic against the model
    gs = 3'd1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        sel = $urandom_range(0, 9);
        if (sel < 4)       gs = 3'd1;
        else if (sel < 6)  gs = 3'd2;
        else if (sel == 6) gs = 3'd0;
        else if (sel == 7) gs = 3'd4;
        else if (sel == 8) gs = 3'd3;
        else               gs = 3'($urandom_range(5, 7));
      end
      r  = ($urandom_range(0, 499) == 0);
      fs = ($urandom_range(0, 11) == 0);
      pd = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      cyc(r, gs, fs, pd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
